// File: rtl/seq_multiplier_nxn_pkg.sv
// ============================================================================
// Package  : seq_mul_pkg
// Brief    : State encoding and width helpers for the sequential multiplier.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_mul_pkg;

    typedef logic [1:0] state_t;

    localparam state_t c_ST_IDLE = 2'd0;
    localparam state_t c_ST_RUN  = 2'd1;
    localparam state_t c_ST_FIX  = 2'd2;
    localparam state_t c_ST_DONE = 2'd3;

    localparam int c_DEFAULT_WIDTH = 8;

    // Counter must reach WIDTH without wrapping.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic int prod_width(input int width);
        return 2 * width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_multiplier_nxn_if.sv
// ============================================================================
// Interface : seq_multiplier_nxn_if
// Brief     : start/done handshake, operands and product of the multiplier.
//             sgn exists only when SEQMUL_SIGNED_EN is defined.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_multiplier_nxn_if
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
);

    logic                         start;
    logic [WIDTH-1:0]             A;
    logic [WIDTH-1:0]             B;
`ifdef SEQMUL_SIGNED_EN
    logic                         sgn;
`endif
    logic                         busy;
    logic                         done;
    logic [prod_width(WIDTH)-1:0] C;

    modport master (
        output start, A, B,
`ifdef SEQMUL_SIGNED_EN
        output sgn,
`endif
        input  busy, done, C
    );

    modport slave (
        input  start, A, B,
`ifdef SEQMUL_SIGNED_EN
        input  sgn,
`endif
        output busy, done, C
    );

endinterface

`default_nettype wire

// File: rtl/seq_multiplier_nxn_datapath.sv
// ============================================================================
// Module   : seq_mul_datapath
// Brief    : Operand, accumulator and shift registers with the shift-add adder.
//            Macro SEQMUL_SIGNED_EN adds magnitude capture and negation on fix.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_mul_datapath
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_load,
    input  logic                         i_step,
`ifdef SEQMUL_SIGNED_EN
    input  logic                         i_fix,
    input  logic                         i_sgn,
`endif
    input  logic [WIDTH-1:0]             i_a,
    input  logic [WIDTH-1:0]             i_b,
    output logic [prod_width(WIDTH)-1:0] o_next_prod
);

    logic [WIDTH-1:0]             r_a;
    logic [WIDTH-1:0]             r_acc_hi;
    logic [WIDTH-1:0]             r_b_sh;
    logic [WIDTH-1:0]             w_a_mag;
    logic [WIDTH-1:0]             w_b_mag;
    logic [WIDTH:0]               w_sum;
    logic [prod_width(WIDTH)-1:0] w_prod;
    logic [prod_width(WIDTH)-1:0] w_next;

`ifdef SEQMUL_SIGNED_EN
    logic r_neg;
    logic w_neg;

    // The most-negative value negates to itself, which read unsigned is its magnitude.
    assign w_a_mag = (i_sgn && i_a[WIDTH-1]) ? -i_a : i_a;
    assign w_b_mag = (i_sgn && i_b[WIDTH-1]) ? -i_b : i_b;
    assign w_neg   = i_sgn && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
`else
    assign w_a_mag = i_a;
    assign w_b_mag = i_b;
`endif

    assign w_sum  = {1'b0, r_acc_hi} + (r_b_sh[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
    assign w_prod = {r_acc_hi, r_b_sh};

    always_comb begin
        w_next = w_prod;
        if (i_step) begin
            w_next = {w_sum, r_b_sh[WIDTH-1:1]};
        end
`ifdef SEQMUL_SIGNED_EN
        else if (i_fix && r_neg) begin
            w_next = -w_prod;
        end
`endif
    end

    assign o_next_prod = w_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_acc_hi <= '0;
            r_b_sh   <= '0;
`ifdef SEQMUL_SIGNED_EN
            r_neg    <= 1'b0;
`endif
        end else if (i_load) begin
            r_a      <= w_a_mag;
            r_acc_hi <= '0;
            r_b_sh   <= w_b_mag;
`ifdef SEQMUL_SIGNED_EN
            r_neg    <= w_neg;
`endif
        end else begin
            {r_acc_hi, r_b_sh} <= w_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/seq_multiplier_nxn.sv
// ============================================================================
// Module   : seq_multiplier_nxn
// Brief    : WIDTH x WIDTH shift-and-add multiplier, one partial product per clock.
//            Macro SEQMUL_SIGNED_EN enables the sgn input and the FIX state.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_multiplier_nxn
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_multiplier_nxn_if.slave  bus
);

    localparam int                 c_CNT_W  = cnt_width(WIDTH);
    localparam int                 c_PROD_W = prod_width(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST   = c_CNT_W'(WIDTH - 1);

    state_t              r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_busy;
    logic                r_done;
    logic [c_PROD_W-1:0] r_c;
    logic                w_load;
    logic                w_step;
    logic [c_PROD_W-1:0] w_next_prod;

    // Start is honoured in DONE as well, so back-to-back ops skip IDLE.
    assign w_load = bus.start && ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE));
    assign w_step = (r_state == c_ST_RUN);

`ifdef SEQMUL_SIGNED_EN
    logic w_fix;
    assign w_fix = (r_state == c_ST_FIX);
`endif

    seq_mul_datapath #(
        .WIDTH       (WIDTH)
    ) u_datapath (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_step      (w_step),
`ifdef SEQMUL_SIGNED_EN
        .i_fix       (w_fix),
        .i_sgn       (bus.sgn),
`endif
        .i_a         (bus.A),
        .i_b         (bus.B),
        .o_next_prod (w_next_prod)
    );

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.C    = r_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_c     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    if (bus.start) begin
                        r_state <= c_ST_RUN;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= c_ST_IDLE;
                    end
                end
                c_ST_RUN: begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                    if (r_cnt == c_LAST) begin
`ifdef SEQMUL_SIGNED_EN
                        r_state <= c_ST_FIX;
`else
                        r_state <= c_ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_c     <= w_next_prod;
`endif
                    end
                end
`ifdef SEQMUL_SIGNED_EN
                c_ST_FIX: begin
                    r_state <= c_ST_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_c     <= w_next_prod;
                end
`endif
                default: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seq_multiplier_nxn.sv
// ============================================================================
// Module   : tb_seq_multiplier_nxn
// Brief    : Scoreboard bench for WIDTH=4 directed and WIDTH=8 random operations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_multiplier_nxn;
    import seq_mul_pkg::*;

`ifdef SEQMUL_SIGNED_EN
    localparam int c_EXTRA = 1;
`else
    localparam int c_EXTRA = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always #5 clk = ~clk;

    seq_multiplier_nxn_if #(.WIDTH(4)) bus4 ();
    seq_multiplier_nxn_if #(.WIDTH(8)) bus8 ();

    seq_multiplier_nxn #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    seq_multiplier_nxn #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    logic [7:0]  exp4_q[$];
    logic [15:0] exp8_q[$];
    int          acc4_q[$];
    int          acc8_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(input int w, input int a, input int b, input bit s);
        int sa;
        int sb;
        int p;
        sa = (s && a >= (1 << (w - 1))) ? a - (1 << w) : a;
        sb = (s && b >= (1 << (w - 1))) ? b - (1 << w) : b;
        p  = sa * sb;
        return p & ((1 << (2 * w)) - 1);
    endfunction

    // Accept edges are recorded by edge index; done is checked against them.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && bus4.start && !bus4.busy) acc4_q.push_back(cyc + 1);
        if (!rst && bus8.start && !bus8.busy) acc8_q.push_back(cyc + 1);
    end

    always @(negedge clk) begin
        if (bus4.done) begin
            chk("sb4_pending", 32'(exp4_q.size() > 0 && acc4_q.size() > 0), 32'd1);
            if (exp4_q.size() > 0 && acc4_q.size() > 0) begin
                chk("c4", bus4.C, exp4_q.pop_front());
                chk("lat4", cyc - acc4_q.pop_front(), 4 + c_EXTRA);
            end
        end
        if (bus8.done) begin
            chk("sb8_pending", 32'(exp8_q.size() > 0 && acc8_q.size() > 0), 32'd1);
            if (exp8_q.size() > 0 && acc8_q.size() > 0) begin
                chk("c8", bus8.C, exp8_q.pop_front());
                chk("lat8", cyc - acc8_q.pop_front(), 8 + c_EXTRA);
            end
        end
    end

    task automatic issue4(input int a, input int b, input bit s);
        logic [31:0] r;
        r = ref_mul(4, a, b, s);
        bus4.A = a[3:0];
        bus4.B = b[3:0];
`ifdef SEQMUL_SIGNED_EN
        bus4.sgn = s;
`endif
        bus4.start = 1'b1;
        exp4_q.push_back(r[7:0]);
        @(negedge clk);
        bus4.start = 1'b0;
    endtask

    task automatic issue8(input int a, input int b, input bit s);
        logic [31:0] r;
        r = ref_mul(8, a, b, s);
        bus8.A = a[7:0];
        bus8.B = b[7:0];
`ifdef SEQMUL_SIGNED_EN
        bus8.sgn = s;
`endif
        bus8.start = 1'b1;
        exp8_q.push_back(r[15:0]);
        @(negedge clk);
        bus8.start = 1'b0;
    endtask

    task automatic wait_done4();
        int k = 0;
        while (!bus4.done && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("done4_seen", 32'(bus4.done), 32'd1);
    endtask

    task automatic wait_done8();
        int k = 0;
        while (!bus8.done && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk("done8_seen", 32'(bus8.done), 32'd1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus4.start = 1'b0; bus4.A = '0; bus4.B = '0;
        bus8.start = 1'b0; bus8.A = '0; bus8.B = '0;
`ifdef SEQMUL_SIGNED_EN
        bus4.sgn = 1'b0;
        bus8.sgn = 1'b0;
`endif
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy4", 32'(bus4.busy), 32'd0);
        chk("rst_done4", 32'(bus4.done), 32'd0);
        chk("rst_c4", bus4.C, 32'd0);
        chk("rst_c8", bus8.C, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single op, then product must hold once done drops
        issue4(10, 11, 1'b0);
        chk("busy4_run", 32'(bus4.busy), 32'd1);
        repeat (2) @(negedge clk);
        chk("done4_early", 32'(bus4.done), 32'd0);
        wait_done4();
        chk("busy4_done", 32'(bus4.busy), 32'd0);
        @(negedge clk);
        chk("done4_pulse", 32'(bus4.done), 32'd0);
        chk("c4_hold", bus4.C, 32'd110);

        // Back-to-back: second start lands in the DONE cycle
        issue4(15, 15, 1'b0);
        wait_done4();
        chk("c4_225", bus4.C, 32'd225);
        issue4(12, 3, 1'b0);
        chk("b2b_busy", 32'(bus4.busy), 32'd1);
        wait_done4();
        chk("c4_36", bus4.C, 32'd36);
        @(negedge clk);

        issue4(0, 9, 1'b0);
        wait_done4();
        chk("c4_zero", bus4.C, 32'd0);
        @(negedge clk);

        // Start during RUN must not disturb the operands
        issue4(5, 6, 1'b0);
        bus4.A = 4'd15; bus4.B = 4'd15; bus4.start = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0;
        wait_done4();
        chk("c4_ignored", bus4.C, 32'd30);
        @(negedge clk);

        // Abort mid-RUN
        issue4(7, 7, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(bus4.busy), 32'd0);
        chk("abort_done", 32'(bus4.done), 32'd0);
        chk("abort_c", bus4.C, 32'd0);
        rst = 1'b0;
        exp4_q.delete();
        acc4_q.delete();
        exp8_q.delete();
        acc8_q.delete();
        issue4(9, 9, 1'b0);
        wait_done4();
        chk("c4_after_rst", bus4.C, 32'd81);
        @(negedge clk);

`ifdef SEQMUL_SIGNED_EN
        issue4(8, 8, 1'b1);
        wait_done4();
        chk("s_m8m8", bus4.C, 32'h40);
        @(negedge clk);
        issue4(8, 7, 1'b1);
        wait_done4();
        chk("s_m8p7", bus4.C, 32'hC8);
        @(negedge clk);
        issue4(3, 11, 1'b1);
        wait_done4();
        chk("s_p3m5", bus4.C, 32'hF1);
        @(negedge clk);
        issue4(15, 15, 1'b0);
        wait_done4();
        chk("u_15x15", bus4.C, 32'hE1);
        @(negedge clk);
`endif

        // Random sweep at WIDTH=8, mix of gaps and back-to-back starts
        for (int i = 0; i < 2000; i++) begin
            int a;
            int b;
            bit s;
            a = $urandom_range(0, 255);
            b = $urandom_range(0, 255);
            if (i % 40 == 0) a = 0;
            if (i % 40 == 1) b = 0;
            if (i % 40 == 2) begin a = 128; b = 128; end
            s = (c_EXTRA != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            issue8(a, b, s);
            wait_done8();
        end

        repeat (3) @(negedge clk);
        chk("sb4_empty", exp4_q.size(), 32'd0);
        chk("sb8_empty", exp8_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
